// File: rtl/perm5_pkg.sv
// perm5_pkg: shared widths, FSM states and PERM5 swap-pair tables
package perm5_pkg;
    localparam int PERM_W   = 5;
    localparam int CTRL_W   = 14;
    localparam int N_STAGES = 7;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    // Swap pair for each control bit, packed so element i belongs to Pi
    localparam logic [CTRL_W-1:0][2:0] PAIR_LO = {3'd1, 3'd0, 3'd1, 3'd2, 3'd0, 3'd1, 3'd3,
                                                  3'd0, 3'd1, 3'd0, 3'd3, 3'd1, 3'd2, 3'd0};
    localparam logic [CTRL_W-1:0][2:0] PAIR_HI = {3'd2, 3'd3, 3'd3, 3'd4, 3'd3, 3'd4, 3'd4,
                                                  3'd2, 3'd3, 3'd4, 3'd4, 3'd2, 3'd3, 3'd1};
endpackage

// File: rtl/perm5_stage.sv
// perm5_stage: one combinational PERM5 butterfly stage (two disjoint swaps)
module perm5_stage
    import perm5_pkg::*;
(
    input  logic [PERM_W-1:0] x_i,
    input  logic [2:0]        stage_i,
    input  logic [1:0]        ctrl_i,
    output logic [PERM_W-1:0] y_o
);
    logic [3:0] hi;
    logic [3:0] lo;
    // Stage s owns control bits P(15-2s) and P(14-2s)
    assign hi = 4'd15 - {stage_i, 1'b0};
    assign lo = hi - 4'd1;
    // Both swaps read the unmodified input; they touch disjoint bits
    always_comb begin
        y_o = x_i;
        if (ctrl_i[1]) begin
            y_o[PAIR_LO[hi]] = x_i[PAIR_HI[hi]];
            y_o[PAIR_HI[hi]] = x_i[PAIR_LO[hi]];
        end
        if (ctrl_i[0]) begin
            y_o[PAIR_LO[lo]] = x_i[PAIR_HI[lo]];
            y_o[PAIR_HI[lo]] = x_i[PAIR_LO[lo]];
        end
    end
endmodule

// File: rtl/perm5_inv_seq.sv
// perm5_inv_seq: iterative forward/inverse PERM5, one stage per clock
module perm5_inv_seq
    import perm5_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PERM_W-1:0] in_x,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic              in_fwd,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PERM_W-1:0] out_y
);
    state_t            state_q, state_d;
    logic [2:0]        stage_q, stage_d;
    logic [PERM_W-1:0] x_q, x_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic              fwd_q, fwd_d;
    logic [3:0]        bit_hi;
    logic [1:0]        stage_ctrl;
    logic [PERM_W-1:0] stage_y;
    logic              last;

    assign bit_hi     = 4'd15 - {stage_q, 1'b0};
    assign stage_ctrl = {ctrl_q[bit_hi], ctrl_q[bit_hi - 4'd1]};
    assign last       = fwd_q ? (stage_q == 3'(N_STAGES)) : (stage_q == 3'd1);
    assign in_ready   = (state_q == IDLE);
    assign out_valid  = (state_q == DONE);
    assign out_y      = x_q;

    perm5_stage u_stage (
        .x_i    (x_q),
        .stage_i(stage_q),
        .ctrl_i (stage_ctrl),
        .y_o    (stage_y)
    );

    // Accept in IDLE, walk the stages up or down in RUN, hold the result in DONE
    always_comb begin
        state_d = state_q;
        stage_d = stage_q;
        x_d     = x_q;
        ctrl_d  = ctrl_q;
        fwd_d   = fwd_q;
        case (state_q)
            IDLE: if (in_valid) begin
                x_d     = in_x;
                ctrl_d  = in_ctrl;
                fwd_d   = in_fwd;
                stage_d = in_fwd ? 3'd1 : 3'(N_STAGES);
                state_d = RUN;
            end
            RUN: begin
                x_d     = stage_y;
                state_d = last ? DONE : RUN;
                stage_d = last ? stage_q : (fwd_q ? stage_q + 3'd1 : stage_q - 3'd1);
            end
            DONE:    state_d = out_ready ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end

    // State registers with synchronous reset discarding any partial result
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            stage_q <= 3'd0;
            x_q     <= '0;
            ctrl_q  <= '0;
            fwd_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            stage_q <= stage_d;
            x_q     <= x_d;
            ctrl_q  <= ctrl_d;
            fwd_q   <= fwd_d;
        end
    end
endmodule

// File: tb/tb_perm5_inv_seq.sv
// tb_perm5_inv_seq: randomized self-checking bench against a per-bit swap model
module tb_perm5_inv_seq;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [4:0]  in_x = '0;
    logic [13:0] in_ctrl = '0;
    logic        in_fwd = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [4:0]  out_y;
    int          checks = 0;
    int          errors = 0;

    localparam int PA[14] = '{0, 2, 1, 3, 0, 1, 0, 3, 1, 0, 2, 1, 0, 1};
    localparam int PB[14] = '{1, 3, 2, 4, 4, 3, 2, 4, 4, 3, 4, 3, 3, 2};

    perm5_inv_seq dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_x     (in_x),
        .in_ctrl  (in_ctrl),
        .in_fwd   (in_fwd),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_y    (out_y)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Forward applies P13 first down to P0; inverse applies P0 first up to P13
    function automatic logic [4:0] model(input logic [4:0] x, input logic [13:0] c, input bit fwd);
        logic [4:0] y = x;
        logic       t;
        for (int k = 0; k < 14; k++) begin
            int i = fwd ? 13 - k : k;
            if (c[i]) begin
                t        = y[PA[i]];
                y[PA[i]] = y[PB[i]];
                y[PB[i]] = t;
            end
        end
        return y;
    endfunction

    task automatic do_req(input logic [4:0] x, input logic [13:0] c, input bit fwd,
                          input int hold, output logic [4:0] y);
        int n = 0;
        check("ready_before_req", 32'(in_ready), 1);
        in_valid = 1'b1; in_x = x; in_ctrl = c; in_fwd = fwd;
        @(negedge clk);
        in_valid = 1'b0; in_x = 5'($urandom); in_ctrl = 14'($urandom); in_fwd = 1'($urandom);
        while (!out_valid && n < 50) begin
            check("ready_low_run", 32'(in_ready), 0);
            @(negedge clk);
            n++;
        end
        check("latency", 32'(n), 7);
        y = out_y;
        repeat (hold) @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    // Handshake monitor: ready/valid exclusive, result frozen under backpressure
    logic       held = 1'b0;
    logic [4:0] held_y = '0;
    always begin
        @(negedge clk);
        #1;
        if (!rst) begin
            check("ready_valid_excl", 32'(in_ready & out_valid), 0);
            if (held && out_valid) check("hold_stable", 32'(out_y), 32'(held_y));
        end
        held   = !rst && out_valid && !out_ready;
        held_y = out_y;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [4:0]  y, y2, x;
        logic [13:0] c;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("rst_ready", 32'(in_ready), 1);
        check("rst_valid", 32'(out_valid), 0);
        check("rst_y", 32'(out_y), 0);

        do_req(5'b10110, 14'h0000, 1'b1, 0, y);
        check("zero_ctrl_fwd", 32'(y), 32'(5'b10110));
        do_req(5'b10110, 14'h0000, 1'b0, 1, y);
        check("zero_ctrl_inv", 32'(y), 32'(5'b10110));
        do_req(5'b00011, 14'h3FFF, 1'b1, 0, y);
        check("all_ones_fwd", 32'(y), 32'(5'b11000));
        do_req(5'b11000, 14'h3FFF, 1'b0, 0, y);
        check("all_ones_inv", 32'(y), 32'(5'b00011));
        do_req(5'b00001, 14'h0001, 1'b0, 0, y);
        check("p0_only_inv", 32'(y), 32'(5'b00010));

        // Backpressure with a competing request held on the input
        in_valid = 1'b1; in_x = 5'b01101; in_ctrl = 14'h2A5C; in_fwd = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        for (int i = 0; i < 12 && !out_valid; i++) @(negedge clk);
        check("bp_valid", 32'(out_valid), 1);
        y = out_y;
        check("bp_result", 32'(y), 32'(model(5'b01101, 14'h2A5C, 1'b1)));
        for (int i = 0; i < 20; i++) begin
            in_valid = 1'b1; in_x = 5'($urandom); in_ctrl = 14'($urandom); in_fwd = 1'($urandom);
            @(negedge clk);
            check("bp_ready_low", 32'(in_ready), 0);
            check("bp_y_stable", 32'(out_y), 32'(y));
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("bp_release_idle", 32'(in_ready), 1);
        check("bp_release_valid", 32'(out_valid), 0);
        @(negedge clk);
        check("bp_no_second_accept", 32'(in_ready), 1);

        // Reset in the middle of RUN
        in_valid = 1'b1; in_x = 5'b11111; in_ctrl = 14'h1234; in_fwd = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrun_rst_ready", 32'(in_ready), 1);
        check("midrun_rst_valid", 32'(out_valid), 0);
        check("midrun_rst_y", 32'(out_y), 0);
        rst = 1'b1; in_valid = 1'b1; in_x = 5'b10101;
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0;
        check("rst_beats_valid", 32'(in_ready), 1);
        @(negedge clk);
        check("rst_beats_valid_idle", 32'(in_ready), 1);
        do_req(5'b10011, 14'h0F0F, 1'b1, 0, y);
        check("post_rst_req", 32'(y), 32'(model(5'b10011, 14'h0F0F, 1'b1)));

        for (int i = 0; i < 1000; i++) begin
            x = 5'($urandom);
            c = 14'($urandom);
            do_req(x, c, 1'b1, int'($urandom_range(0, 2)), y);
            check("rand_fwd", 32'(y), 32'(model(x, c, 1'b1)));
            do_req(y, c, 1'b0, int'($urandom_range(0, 2)), y2);
            check("rand_inv", 32'(y2), 32'(model(y, c, 1'b0)));
            check("rand_round_trip", 32'(y2), 32'(x));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/perm5_inv_seq.md
# perm5_inv_seq

Iterative PERM5 permutation engine for the hop-selection datapath. It applies the 7 butterfly stages of the Bluetooth PERM5 network one stage per clock, controlled by a 14-bit control word. Inverse mode undoes the forward hop permutation, which the receive-side hop checker and the self-test need. Forward mode provides a round-trip reference. It sits between the hop-kernel adder stage and the register-bank mapping, behind a valid/ready handshake.

## Interface
- Parameters: none. All widths are fixed by the PERM5 definition.
- `clk`  in  1  — single clock; all state changes on the rising edge.
- `rst`  in  1  — synchronous, active-high reset.
- `in_valid`  in  1  — request present.
- `in_ready`  out  1  — engine can accept a request; high only in IDLE.
- `in_x`  in  5  — word to permute.
- `in_ctrl`  in  14  — control word P13..P0; bit Pi=1 swaps its pair.
- `in_fwd`  in  1  — 1 = forward PERM5, 0 = inverse.
- `out_valid`  out  1  — result available.
- `out_ready`  in  1  — consumer accepts the result.
- `out_y`  out  5  — permuted result; stable while `out_valid`=1.

## Operation
- Stage s (1..7) uses control bits P(15−2s) and P(14−2s). Each bit controls one swap:
  - s1: P13 swaps (1,2), P12 swaps (0,3)
  - s2: P11 swaps (1,3), P10 swaps (2,4)
  - s3: P9 swaps (0,3), P8 swaps (1,4)
  - s4: P7 swaps (3,4), P6 swaps (0,2)
  - s5: P5 swaps (1,3), P4 swaps (0,4)
  - s6: P3 swaps (3,4), P2 swaps (1,2)
  - s7: P1 swaps (2,3), P0 swaps (0,1)
- The two swaps within a stage are disjoint, so they are applied together in one cycle.
- Forward mode applies s1→s7. Inverse mode applies s7→s1.
- State machine:
  - IDLE: `in_ready`=1. If `in_valid`=1, capture `in_x`, `in_ctrl` and `in_fwd`. Set the stage counter to 1 (forward) or 7 (inverse) and go to RUN.
  - RUN: apply the current stage to the working register. The counter steps +1 (forward) or −1 (inverse). After the last stage (s7 forward, s1 inverse), go to DONE.
  - DONE: `out_valid`=1 and `out_y` = working register. If `out_ready`=1, go to IDLE. Otherwise hold with `out_y` unchanged.
- Inputs are sampled only at acceptance. Changes to `in_*` after acceptance have no effect.
- The stage counter is 3 bits and never leaves the range 1..7. Values 0 and 7→8 are never used as a stage.

## Timing
- Reset values: state=IDLE, `in_ready`=1, `out_valid`=0, `out_y`=5'b00000, stage counter=0.
- Latency: if acceptance is on edge E0, `out_valid` rises right after edge E7 (7 RUN cycles).
- Minimum throughput: one request per 9 cycles (7 RUN + 1 DONE with `out_ready`=1 + 1 IDLE).
- `in_ready` is low throughout RUN and DONE. `in_valid` is ignored there; no request is queued.
- Backpressure: DONE holds indefinitely. `out_y` must not change while `out_valid`=1 and `out_ready`=0.
- `rst` has priority over any state, including mid-RUN and DONE. On the next edge the engine is back in IDLE with reset values, and the partial result is discarded.
- `rst` and `in_valid` high together: reset wins and nothing is accepted.

## Structure
- Shared package `perm5_pkg`:
  - state enum {IDLE, RUN, DONE}
  - constants for the 14 swap pairs (index pairs per control bit)
  - `PERM_W`=5, `CTRL_W`=14, `N_STAGES`=7
- One sub-module: `perm5_stage`. It is combinational; inputs are a 5-bit word, the stage index and the 2 control bits; output is the swapped word. It is instantiated once and time-multiplexed by the counter.
- The forward PERM5 block reuses `perm5_stage`.

## Test plan
- `in_ctrl`=14'h0000, `in_x`=5'b10110, either mode → `out_y`=5'b10110 with `out_valid` rising exactly 7 cycles after acceptance.
- Forward, `in_ctrl`=14'h3FFF, `in_x`=5'b00011 → `out_y`=5'b11000. Inverse, `in_ctrl`=14'h3FFF, `in_x`=5'b11000 → `out_y`=5'b00011.
- Inverse, `in_ctrl`=14'h0001, `in_x`=5'b00001 → `out_y`=5'b00010 (P0 swaps bits 0 and 1 only).
- Hold `out_ready`=0 for 20 cycles in DONE while `in_valid`=1 with new data → `out_y` stable, `in_ready`=0, no second acceptance. Release `out_ready` → IDLE on the next edge.
- Assert `rst` at RUN cycle 4 → next cycle `in_ready`=1, `out_valid`=0, `out_y`=0. A following request completes with correct data.
- Random round trip: 1000 random (x, ctrl) pairs, forward then inverse → output equals the original x. Handshake assertions hold throughout.
